// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Operand-mux selects, FSM states and the shadow-stage control record.
package hazard_pkg;

  // Width of a register address; the top-level RB parameter must match it.
  localparam int unsigned REG_W = 4;

  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE,
    BUSY
  } hz_state_t;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             rw;
    logic             m2r;
    logic             mc;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding compare for one Execute operand.
// The M stage has priority over W, and R15 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned RB = 4
) (
  input  logic [RB-1:0] ra_i,
  input  logic          ra_vld_i,
  input  logic [RB-1:0] dst_m_i,
  input  logic          rw_m_i,
  input  logic [RB-1:0] dst_w_i,
  input  logic          rw_w_i,
  output fwd_sel_t      sel_o
);

  logic hit_m, hit_w;

  always_comb begin
    hit_m = ra_vld_i && rw_m_i && (dst_m_i == ra_i) && (dst_m_i != RB'(PC_REG));
    hit_w = ra_vld_i && rw_w_i && (dst_w_i == ra_i) && (dst_w_i != RB'(PC_REG));
    sel_o = FWD_RF;
    if (hit_w) sel_o = FWD_W;
    if (hit_m) sel_o = FWD_M;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: shadow E/M/W control bits, operand
// forwarding, load-use stalls, branch flushes and a multicycle-op hold FSM.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned RB      = REG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RB-1:0] Ra1D,
  input  logic [RB-1:0] Ra2D,
  input  logic          Use1D,
  input  logic          Use2D,
  input  logic [RB-1:0] WriteAddrD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MultiD,
  input  logic          BranchTakenE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM
);

  localparam logic [3:0] CntLast = 4'(MUL_LAT - 1);

  stage_ctl_t    e_q;
  logic [RB-1:0] ra1_e_q, ra2_e_q;
  logic          ra1_vld_e_q, ra2_vld_e_q;
  logic [RB-1:0] dst_m_q, dst_w_q;
  logic          rw_m_q, rw_w_q;

  hz_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic     ld_stall, busy;
  fwd_sel_t sel_a, sel_b;

  hazard_fwd_sel #(.RB(RB)) u_fwd_a (
    .ra_i    (ra1_e_q),
    .ra_vld_i(ra1_vld_e_q),
    .dst_m_i (dst_m_q),
    .rw_m_i  (rw_m_q),
    .dst_w_i (dst_w_q),
    .rw_w_i  (rw_w_q),
    .sel_o   (sel_a)
  );

  hazard_fwd_sel #(.RB(RB)) u_fwd_b (
    .ra_i    (ra2_e_q),
    .ra_vld_i(ra2_vld_e_q),
    .dst_m_i (dst_m_q),
    .rw_m_i  (rw_m_q),
    .dst_w_i (dst_w_q),
    .rw_w_i  (rw_w_q),
    .sel_o   (sel_b)
  );

  assign ld_stall = e_q.rw && e_q.m2r &&
                    ((Use1D && (Ra1D == e_q.dst)) || (Use2D && (Ra2D == e_q.dst)));

  // Last BUSY cycle is not busy: the op leaves E at the end of it.
  assign busy = ((state_q == IDLE) && e_q.mc) || ((state_q == BUSY) && (cnt_q < CntLast));

  always_comb begin
    ForwardAE = sel_a;
    ForwardBE = sel_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      state_d   = IDLE;
      cnt_d     = 4'd0;
    end else if (BranchTakenE) begin
      FlushD  = 1'b1;
      FlushE  = 1'b1;
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      if (busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (ld_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (e_q.mc) begin
            state_d = BUSY;
            cnt_d   = 4'd1;
          end
        end
        BUSY: begin
          if (cnt_q == CntLast) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      ra1_e_q     <= '0;
      ra2_e_q     <= '0;
      ra1_vld_e_q <= 1'b0;
      ra2_vld_e_q <= 1'b0;
      dst_m_q     <= '0;
      rw_m_q      <= 1'b0;
      dst_w_q     <= '0;
      rw_w_q      <= 1'b0;
    end else begin
      if (FlushE) begin
        e_q         <= '0;
        ra1_e_q     <= '0;
        ra2_e_q     <= '0;
        ra1_vld_e_q <= 1'b0;
        ra2_vld_e_q <= 1'b0;
      end else if (!StallE) begin
        e_q.dst     <= WriteAddrD;
        e_q.rw      <= RegWriteD;
        e_q.m2r     <= MemtoRegD;
        e_q.mc      <= MultiD;
        ra1_e_q     <= Use1D ? Ra1D : '0;
        ra2_e_q     <= Use2D ? Ra2D : '0;
        ra1_vld_e_q <= Use1D;
        ra2_vld_e_q <= Use2D;
      end
      if (FlushM) begin
        dst_m_q <= '0;
        rw_m_q  <= 1'b0;
      end else begin
        dst_m_q <= e_q.dst;
        rw_m_q  <= e_q.rw;
      end
      dst_w_q <= dst_m_q;
      rw_w_q  <= rw_m_q;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed Decode-stage vectors with hand-computed
// per-cycle control outputs, checked by an independent negedge monitor.
module tb_hazard_ctrl;

  typedef struct {
    logic [3:0] r1;
    logic       u1;
    logic [3:0] r2;
    logic       u2;
    logic [3:0] wa;
    logic       rw;
    logic       m2r;
    logic       mc;
  } instr_t;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  // Packed as {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM}
  localparam logic [9:0] E_ZERO = 10'b00_00_000_000;
  localparam logic [9:0] E_RST  = 10'b00_00_000_111;
  localparam logic [9:0] E_BUSY = 10'b00_00_111_001;
  localparam logic [9:0] E_LDS  = 10'b00_00_110_010;
  localparam logic [9:0] E_BR   = 10'b00_00_000_110;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Ra1D, Ra2D, WriteAddrD;
  logic       Use1D, Use2D, RegWriteD, MemtoRegD, MultiD, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .RB(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .Ra1D        (Ra1D),
    .Ra2D        (Ra2D),
    .Use1D       (Use1D),
    .Use2D       (Use2D),
    .WriteAddrD  (WriteAddrD),
    .RegWriteD   (RegWriteD),
    .MemtoRegD   (MemtoRegD),
    .MultiD      (MultiD),
    .BranchTakenE(BranchTakenE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM)
  );

  function automatic instr_t ins(input logic [3:0] r1, input logic u1, input logic [3:0] r2,
                                 input logic u2, input logic [3:0] wa, input logic rw,
                                 input logic m2r, input logic mc);
    instr_t i;
    i.r1 = r1; i.u1 = u1; i.r2 = r2; i.u2 = u2;
    i.wa = wa; i.rw = rw; i.m2r = m2r; i.mc = mc;
    return i;
  endfunction

  function automatic logic [9:0] fwd(input logic [1:0] a, input logic [1:0] b,
                                     input logic [9:0] base);
    return {a, b, base[5:0]};
  endfunction

  task automatic drive(input logic rst, input instr_t i, input logic br);
    reset        = rst;
    Ra1D         = i.r1;
    Use1D        = i.u1;
    Ra2D         = i.r2;
    Use2D        = i.u2;
    WriteAddrD   = i.wa;
    RegWriteD    = i.rw;
    MemtoRegD    = i.m2r;
    MultiD       = i.mc;
    BranchTakenE = br;
  endtask

  task automatic cyc(input string nm, input logic rst, input instr_t i, input logic br,
                     input logic [9:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    drive(rst, i, br);
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t       e;
      logic [9:0] got;
      e   = sb_q.pop_front();
      got = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM};
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got %b required %b (FA FB SF SD SE FD FE FM)", e.name, got, e.exp);
      end
    end
  end

  initial begin
    instr_t nop;
    instr_t add_r3, sub_r5, add_r6, ldr_r2, add_r8, mul_r9, use_r9, ldr_r4, br_use_r4;
    instr_t mul_r1, wr_r15, rd_r15, ldr_r5, nouse_r5;
    int     guard;
    nop       = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add_r3    = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    sub_r5    = ins(4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    add_r6    = ins(4'd3, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    ldr_r2    = ins(4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    add_r8    = ins(4'd7, 1'b1, 4'd2, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    mul_r9    = ins(4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1);
    use_r9    = ins(4'd9, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0);
    ldr_r4    = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
    br_use_r4 = ins(4'd4, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0);
    mul_r1    = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
    wr_r15    = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    rd_r15    = ins(4'd15, 1'b1, 4'd15, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0);
    ldr_r5    = ins(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    nouse_r5  = ins(4'd5, 1'b0, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);

    drive(1'b1, nop, 1'b0);
    cyc("reset0", 1'b1, nop, 1'b0, E_RST);
    cyc("reset1", 1'b1, nop, 1'b0, E_RST);

    // Forwarding: M beats W, then W alone; operand B picks up M.
    cyc("fw_i1", 1'b0, add_r3, 1'b0, E_ZERO);
    cyc("fw_i2", 1'b0, add_r3, 1'b0, E_ZERO);
    cyc("fw_i3", 1'b0, sub_r5, 1'b0, E_ZERO);
    cyc("fw_m_prio", 1'b0, add_r6, 1'b0, fwd(2'b10, 2'b00, E_ZERO));
    cyc("fw_w_only", 1'b0, nop, 1'b0, fwd(2'b01, 2'b10, E_ZERO));

    // Load-use: one bubble, then W forwarding into operand B.
    cyc("ld_issue", 1'b0, ldr_r2, 1'b0, E_ZERO);
    cyc("ld_stall", 1'b0, add_r8, 1'b0, E_LDS);
    cyc("ld_bubble", 1'b0, add_r8, 1'b0, E_ZERO);

    // Multicycle op: 3 busy cycles, forward select tracks ADD r8 from M to W.
    cyc("ld_fwd_w", 1'b0, mul_r9, 1'b0, fwd(2'b00, 2'b01, E_ZERO));
    cyc("mul_busy1", 1'b0, use_r9, 1'b0, fwd(2'b10, 2'b00, E_BUSY));
    cyc("mul_busy2", 1'b0, use_r9, 1'b0, fwd(2'b01, 2'b00, E_BUSY));
    cyc("mul_busy3", 1'b0, use_r9, 1'b0, E_BUSY);
    cyc("mul_release", 1'b0, use_r9, 1'b0, E_ZERO);
    cyc("mul_fwd_m", 1'b0, nop, 1'b0, fwd(2'b10, 2'b00, E_ZERO));

    // Taken branch overrides a pending load-use stall.
    cyc("br_ldr", 1'b0, ldr_r4, 1'b0, E_ZERO);
    cyc("br_over_ld", 1'b0, br_use_r4, 1'b1, E_BR);
    cyc("br_after", 1'b0, nop, 1'b0, E_ZERO);

    // Reset in the middle of a multicycle op.
    cyc("rmul_issue", 1'b0, mul_r1, 1'b0, E_ZERO);
    cyc("rmul_busy1", 1'b0, nop, 1'b0, E_BUSY);
    cyc("rmul_busy2", 1'b0, nop, 1'b0, E_BUSY);
    cyc("rmul_reset", 1'b1, nop, 1'b0, E_RST);
    cyc("rmul_idle1", 1'b0, nop, 1'b0, E_ZERO);
    cyc("rmul_idle2", 1'b0, nop, 1'b0, E_ZERO);

    // R15 is never forwarded.
    cyc("r15_wr", 1'b0, wr_r15, 1'b0, E_ZERO);
    cyc("r15_rd", 1'b0, rd_r15, 1'b0, E_ZERO);
    cyc("r15_no_fwd", 1'b0, nop, 1'b0, E_ZERO);

    // Load followed by an instruction that names r5 but does not read it.
    cyc("ldu_issue", 1'b0, ldr_r5, 1'b0, E_ZERO);
    cyc("ldu_unused_src", 1'b0, nouse_r5, 1'b0, E_ZERO);
    cyc("ldu_after", 1'b0, nop, 1'b0, E_ZERO);

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the five-stage ARM core. It sequences the Execute stage: it drives the Exec stall/flush inputs and the forwardAE/forwardBE operand-mux selects, and it generates StallF/StallD/FlushD for Fetch and Decode. It keeps its own shadow copy of the destination and control bits for the E, M and W stages. It also runs a small FSM that holds a multicycle (multiply) op in Execute for MUL_LAT cycles.

Parameters:
MUL_LAT, 4, total cycles a multicycle op occupies Execute; legal range 2..15.
RB, 4, register-address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
Ra1D  in  RB  source reg 1 of the instruction in Decode
Ra2D  in  RB  source reg 2 of the instruction in Decode
Use1D  in  1  Ra1D is actually read
Use2D  in  1  Ra2D is actually read
WriteAddrD  in  RB  destination reg of the Decode instruction
RegWriteD  in  1  Decode instruction writes the register file
MemtoRegD  in  1  Decode instruction is a load
MultiD  in  1  Decode instruction is multicycle
BranchTakenE  in  1  branch in Execute resolved taken
ForwardAE  out  2  00 Rd1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  same encoding for operand B
StallF  out  1  hold PC
StallD  out  1  hold D register
StallE  out  1  hold E register (Exec stall)
FlushD  out  1  bubble into D
FlushE  out  1  bubble into E (Exec flush)
FlushM  out  1  bubble into M

Behaviour:
- Shadow pipeline, updated on clk:
  - E stage: ra1E, ra2E, dstE, rwE, m2rE, mcE.
  - M stage: dstM, rwM.
  - W stage: dstW, rwW.
- Shadow stage advance:
  - E: holds if StallE. Loads zeros for all control bits if FlushE. Otherwise loads the D inputs, with Ra*D gated by Use*D (unused sources are stored as invalid).
  - M: loads zeros if FlushM, else loads from E.
  - W: always loads from M.
- Forwarding (combinational):
  - ForwardAE=10 if rwM && dstM==ra1E && ra1E valid && dstM!=15.
  - Otherwise ForwardAE=01 if the same test passes on the W stage.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules on ra2E.
  - M has priority over W. R15 is never forwarded.
- ldStall = rwE && m2rE && ((Use1D && Ra1D==dstE) || (Use2D && Ra2D==dstE)).
- FSM states:
  - IDLE to BUSY when mcE=1 with valid control bits; cnt<=1.
  - BUSY: cnt increments each cycle. BUSY to IDLE when cnt==MUL_LAT-1; that cycle E advances and cnt<=0.
- busy = (IDLE && mcE) || (BUSY && cnt<MUL_LAT-1).
- Output priority, highest first:
  1. reset: all Stall*=0, FlushD=FlushE=FlushM=1, Forward*=00. Shadow regs and cnt clear, state IDLE. Reset asserted mid-BUSY aborts the op; the next cycle is IDLE.
  2. BranchTakenE: FlushD=FlushE=1, StallF=StallD=StallE=0, FlushM=0. If BUSY, go to IDLE and clear cnt.
  3. busy: StallF=StallD=StallE=1, FlushM=1, FlushE=0. A load-use hazard during busy is held, not flushed.
  4. ldStall: StallF=StallD=1, FlushE=1, StallE=0.
  5. Otherwise all 0.
- Latencies:
  - A multicycle op remains in E for exactly MUL_LAT cycles and emits MUL_LAT-1 M bubbles.
  - A load-use hazard costs exactly 1 bubble.
  - A taken branch kills 2 instructions (D and E).
- MUL_LAT=2 passes through BUSY for one cycle only.
- Forward selects are driven in BUSY from frozen E sources and keep tracking writes that complete in M/W.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}.
  - hz_state_t {IDLE, BUSY}.
  - constant PC_REG=4'd15.
  - struct stage_ctl_t {dst, rw, m2r, mc}.
- One sub-module, hazard_fwd_sel: a combinational compare for one operand, instantiated twice (for A and B).

Test Plan:
- ADD r3 in M, SUB reading r3 as Rn in E, W also writing r3 -> ForwardAE=10 (M wins); next cycle with only W matching -> 01.
- LDR r2 in E, ADD in D with Ra2D=2, Use2D=1 -> one cycle of StallF=StallD=FlushE=1; next cycle ForwardBE=01 (load now in W, add in E), no stall.
- MUL with MUL_LAT=4 enters E -> StallE/StallD/StallF/FlushM high for 3 cycles, low on the 4th; exactly 3 M bubbles observed.
- BranchTakenE=1 with ldStall also true -> FlushD=FlushE=1, StallF=0, StallD=0.
- Reset asserted at cnt=2 of a MUL -> next cycle state IDLE, cnt=0, all stalls 0, Forward*=00.
- rwM=1, dstM=15, ra1E=15 -> ForwardAE=00.
